// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: DEPTH-entry elastic buffer between two pipeline stages
// using the valid/allowin handshake. It supports synchronous flush and
// reports its occupancy.
// Define PIPE_STAGE_FIFO_PERF_EN to add the saturating stall_cnt/full_cnt
// performance counters.
module pipe_stage_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
`ifdef PIPE_STAGE_FIFO_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       full_cnt
`endif
);

  // A pointer is kept at least one bit wide so that DEPTH=1 still elaborates.
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  // Modulo-DEPTH pointer advance, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A slot freed by a same-cycle pop can take a push. Flush blocks all pushes.
  assign w_full     = (r_count == CNT_FULL);
  assign in_allowin = ~flush & (~w_full | out_allowin);
  assign w_push     = in_valid & in_allowin;
  assign w_pop      = out_valid & out_allowin;

  // out_valid depends only on registered occupancy, never on in_valid.
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  // When the buffer is empty the head slot is don't-care, so drive zero.
  // This also makes out_data read 0 out of reset without clearing storage.
  assign out_data  = out_valid ? r_mem[r_head] : '0;

  // Pointer and occupancy state. Flush takes priority over push and pop.
  // NOTE: use non-blocking (<=) for all state so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage is written on push and is never interpreted.
  // NOTE: storage is deliberately left without reset. Validity lives in
  // r_count alone, so clearing the data array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= in_data;
  end

`ifdef PIPE_STAGE_FIFO_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_full_cnt;

  // Saturating counts of downstream stalls and upstream blocking. A flush
  // does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_full_cnt  <= '0;
    end else begin
      if (out_valid && !out_allowin && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_full && in_valid && !out_allowin && (r_full_cnt != '1))
        r_full_cnt <= r_full_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign full_cnt  = r_full_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: a directed vector table on a DEPTH=2 instance, a
// wrap-around sequence and random traffic on a DEPTH=3 instance checked
// against a queue model, plus asynchronous reset and the optional
// performance counters.
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // DEPTH=2 instance with 32-bit payload.
  logic        f2 = 0, iv2 = 0, oa2 = 0;
  logic [31:0] d2 = '0;
  logic        ia2, ov2;
  logic [31:0] do2;
  logic [1:0]  cnt2;

  // DEPTH=3 instance with 8-bit payload.
  logic        f3 = 0, iv3 = 0, oa3 = 0;
  logic [7:0]  d3 = '0;
  logic        ia3, ov3;
  logic [7:0]  do3;
  logic [1:0]  cnt3;

`ifdef PIPE_STAGE_FIFO_PERF_EN
  logic [31:0] stall2, full2, stall3, full3;
`endif

  pipe_stage_fifo #(.DATA_W(32), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_allowin(ia2),
    .in_data(d2), .out_valid(ov2), .out_allowin(oa2), .out_data(do2),
    .count(cnt2)
`ifdef PIPE_STAGE_FIFO_PERF_EN
    , .stall_cnt(stall2), .full_cnt(full2)
`endif
  );

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(f3), .in_valid(iv3), .in_allowin(ia3),
    .in_data(d3), .out_valid(ov3), .out_allowin(oa3), .out_data(do3),
    .count(cnt3)
`ifdef PIPE_STAGE_FIFO_PERF_EN
    , .stall_cnt(stall3), .full_cnt(full3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One directed vector: the inputs for a cycle, the in_allowin expected
  // before the edge, and the state expected after it.
  typedef struct packed {
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        oa;
    logic        e_ia;
    logic        e_ov;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  // Reference model for u3: a queue that holds the buffered payloads.
  logic [7:0] q3 [$];
  logic [7:0] got3 [$];

  // One cycle on u3. Expectations are derived from the queue model.
  task automatic cyc3(input logic f, input logic iv, input logic [7:0] d,
                      input logic oa, output logic pushed);
    logic ia_m, pop_m;
    f3 = f; iv3 = iv; d3 = d; oa3 = oa;
    #1;
    ia_m   = !f && ((q3.size() < 3) || oa);
    pop_m  = (q3.size() > 0) && oa;
    pushed = iv && ia_m;
    check("d3_in_allowin", 32'(ia3), 32'(ia_m));
    if (ov3 && oa) got3.push_back(do3);
    @(posedge clk); #1;
    if (f) q3.delete();
    else begin
      if (pop_m) void'(q3.pop_front());
      if (pushed) q3.push_back(d);
    end
    check("d3_out_valid", 32'(ov3), 32'(q3.size() != 0));
    check("d3_count", 32'(cnt3), 32'(q3.size()));
    if (q3.size() != 0) check("d3_out_data", 32'(do3), 32'(q3[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic pushed;
    int   npush;

    // Stream through a DEPTH=2 buffer with the downstream always ready.
    vecs[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0};
    // Fill under back-pressure. 0xA3 is refused, then the buffer drains in order.
    vecs[4]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0};
    // When full, a push and a pop happen in the same cycle.
    vecs[9]  = '{1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB1, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hB1, 2'd2};
    vecs[11] = '{1'b0, 1'b1, 32'hB3, 1'b1, 1'b1, 1'b1, 32'hB2, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB3, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hB3, 2'd1};
    // Flush while full and while an input is offered. 0xC0 never appears.
    vecs[14] = '{1'b0, 1'b1, 32'hD1, 1'b0, 1'b1, 1'b1, 32'hB3, 2'd2};
    vecs[15] = '{1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0};
    vecs[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0};
    vecs[17] = '{1'b0, 1'b1, 32'hE1, 1'b0, 1'b1, 1'b1, 32'hE1, 2'd1};
    // Flush while a pop is presented in the same cycle.
    vecs[18] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};

    // Values while reset is asserted.
    #2;
    check("rst_out_valid", 32'(ov2), 32'(0));
    check("rst_count", 32'(cnt2), 32'(0));
    check("rst_out_data", do2, 32'h0);
    check("rst_in_allowin", 32'(ia2), 32'(1));
    #15 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      f2 = vecs[i].flush; iv2 = vecs[i].iv; d2 = vecs[i].d; oa2 = vecs[i].oa;
      #1;
      check($sformatf("v%0d_in_allowin", i), 32'(ia2), 32'(vecs[i].e_ia));
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 32'(ov2), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_count", i), 32'(cnt2), 32'(vecs[i].e_cnt));
      if (vecs[i].e_ov)
        check($sformatf("v%0d_out_data", i), do2, vecs[i].e_data);
    end

    // Assert reset asynchronously while one entry is held.
    f2 = 0; iv2 = 1; d2 = 32'hF1; oa2 = 0;
    @(posedge clk); #1;
    iv2 = 0;
    check("pre_arst_count", 32'(cnt2), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(ov2), 32'(0));
    check("arst_count", 32'(cnt2), 32'(0));
    #3 rst = 1'b0;
    @(posedge clk); #1;

`ifdef PIPE_STAGE_FIFO_PERF_EN
    // Hold one entry for 5 stalled edges, then reset clears the counters.
    iv2 = 1; d2 = 32'h55; oa2 = 0;
    @(posedge clk); #1;
    iv2 = 0;
    repeat (5) @(posedge clk);
    #1;
    check("perf_stall_cnt", stall2, 32'd5);
    check("perf_full_cnt", full2, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("perf_stall_rst", stall2, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
`endif

    // Wrap-around on DEPTH=3: push 0..9 with interleaved stalls on both sides.
    npush = 0;
    for (int c = 0; c < 60 && got3.size() < 10; c++) begin
      cyc3(1'b0, (npush < 10) && (c % 4 != 3), 8'(npush), (c % 3 != 1), pushed);
      if (pushed) npush++;
    end
    check("wrap_out_count", 32'(got3.size()), 32'd10);
    for (int i = 0; i < 10 && i < got3.size(); i++)
      check($sformatf("wrap_seq%0d", i), 32'(got3[i]), 32'(i));

    // Random traffic against the queue model, with an occasional flush.
    for (int c = 0; c < 400; c++)
      cyc3(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           8'($urandom), $urandom_range(0, 2) != 0, pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
